// File: rtl/vga_canvas_renderer_if.sv
// Cursor/pen/clear control bundle between the mouse front-end and vga_canvas_renderer.
interface vga_canvas_renderer_if;
  logic [10:0] iCursorX;
  logic [10:0] iCursorY;
  logic        iPenDown;
  logic        iErase;
  logic        iClear;
  logic        oBusy;

  modport slave  (input  iCursorX, iCursorY, iPenDown, iErase, iClear, output oBusy);
  modport master (output iCursorX, iCursorY, iPenDown, iErase, iClear, input  oBusy);
endinterface

// File: rtl/vga_canvas_renderer.sv
// VGA timing generator plus GRIDxGRID binary drawing canvas with pen, erase and row-sweep clear.
// Optional cell grid guide lines (CCC) on the canvas when VGA_GRID_LINES_EN is defined.
module vga_canvas_renderer #(
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int H_ACT     = 800,
  parameter int H_FP      = 40,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int V_ACT     = 600,
  parameter int V_FP      = 1,
  parameter int GRID_LOG2 = 5,
  parameter int CELL_LOG2 = 4,
  parameter int CURSOR_R  = 8
) (
  input  logic                             clkVga,
  input  logic                             iRstN,
  vga_canvas_renderer_if.slave             ctl,
  output logic [3:0]                       oRed,
  output logic [3:0]                       oGreen,
  output logic [3:0]                       oBlue,
  output logic                             oHs,
  output logic                             oVs,
  output logic                             oFrameStart,
  output logic [(1<<(2*GRID_LOG2))-1:0]    oImage
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GRID    = 1 << GRID_LOG2;

  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ASTART   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_AEND     = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ASTART   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_AEND     = VW'(V_SYNC + V_BP + V_ACT);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [11:0]   CANVAS_PX  = 12'(1 << (GRID_LOG2 + CELL_LOG2));
  localparam logic [11:0]   CUR_R      = 12'(CURSOR_R);

`ifdef VGA_GRID_LINES_EN
  localparam logic GRID_EN = 1'b1;
`else
  localparam logic GRID_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  logic [HW-1:0]                    r_hCnt;
  logic [VW-1:0]                    r_vCnt;
  logic [GRID-1:0][GRID-1:0]        r_canvas;
  state_t                           r_state, w_stateNxt;
  logic [GRID_LOG2-1:0]             r_row, w_rowNxt;
  logic [11:0]                      r_rgb;
  logic                             r_hs, r_vs, r_fs;

  logic        w_active, w_inCanvas, w_cursorHit, w_inked, w_gridLine;
  logic        w_curInCanvas, w_penWe, w_clrWe;
  logic [11:0] w_hPos, w_vPos, w_curX, w_curY, w_dx, w_dy, w_rgb;
  logic [GRID_LOG2-1:0] w_curRow, w_curCol;

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == H_LAST) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 1'b1;
    end else begin
      r_hCnt <= r_hCnt + 1'b1;
    end
  end

  assign w_active   = (r_hCnt >= H_ASTART) && (r_hCnt < H_AEND) &&
                      (r_vCnt >= V_ASTART) && (r_vCnt < V_AEND);
  assign w_hPos     = 12'(r_hCnt) - 12'(H_ASTART);
  assign w_vPos     = 12'(r_vCnt) - 12'(V_ASTART);
  assign w_inCanvas = (w_hPos < CANVAS_PX) && (w_vPos < CANVAS_PX);
  assign w_inked    = r_canvas[w_vPos[CELL_LOG2 +: GRID_LOG2]][w_hPos[CELL_LOG2 +: GRID_LOG2]];
  assign w_gridLine = (w_hPos[CELL_LOG2-1:0] == '0) || (w_vPos[CELL_LOG2-1:0] == '0);

  // Absolute distance taken by ordering the operands, so no unsigned wrap near the edges
  assign w_curX      = {1'b0, ctl.iCursorX};
  assign w_curY      = {1'b0, ctl.iCursorY};
  assign w_dx        = (w_hPos >= w_curX) ? (w_hPos - w_curX) : (w_curX - w_hPos);
  assign w_dy        = (w_vPos >= w_curY) ? (w_vPos - w_curY) : (w_curY - w_vPos);
  assign w_cursorHit = (w_dx <= CUR_R) && (w_dy <= CUR_R);

  always_comb begin
    w_rgb = 12'h222;
    if (w_active) begin
      if (w_cursorHit)
        w_rgb = ctl.iPenDown ? (ctl.iErase ? 12'h0F0 : 12'h00F) : 12'hF00;
      else if (w_inCanvas && w_inked)
        w_rgb = 12'hF0F;
      else if (w_inCanvas)
        w_rgb = (GRID_EN && w_gridLine) ? 12'hCCC : 12'hFFF;
      else
        w_rgb = 12'h33F;
    end
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      r_rgb <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= (r_hCnt >= H_SYNC_END);
      r_vs  <= (r_vCnt >= V_SYNC_END);
      r_fs  <= (r_hCnt == '0) && (r_vCnt == '0);
    end
  end

  assign w_curInCanvas = (w_curX < CANVAS_PX) && (w_curY < CANVAS_PX);
  assign w_curRow      = ctl.iCursorY[CELL_LOG2 +: GRID_LOG2];
  assign w_curCol      = ctl.iCursorX[CELL_LOG2 +: GRID_LOG2];

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_row   <= w_rowNxt;
    end
  end

  // iClear takes precedence over a simultaneous pen write
  always_comb begin
    w_stateNxt = r_state;
    w_rowNxt   = r_row;
    w_penWe    = 1'b0;
    w_clrWe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctl.iClear) begin
          w_stateNxt = S_CLEAR;
          w_rowNxt   = '0;
        end else if (ctl.iPenDown && w_curInCanvas) begin
          w_penWe = 1'b1;
        end
      end
      S_CLEAR: begin
        w_clrWe  = 1'b1;
        w_rowNxt = r_row + 1'b1;
        if (r_row == '1) w_stateNxt = S_IDLE;
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN)
      r_canvas <= '0;
    else if (w_clrWe)
      r_canvas[r_row] <= '0;
    else if (w_penWe)
      r_canvas[w_curRow][w_curCol] <= ~ctl.iErase;
  end

  assign ctl.oBusy   = (r_state == S_CLEAR);
  assign oRed        = r_rgb[11:8];
  assign oGreen      = r_rgb[7:4];
  assign oBlue       = r_rgb[3:0];
  assign oHs         = r_hs;
  assign oVs         = r_vs;
  assign oFrameStart = r_fs;
  assign oImage      = r_canvas;
endmodule

// File: tb/tb_vga_canvas_renderer.sv
// Scoreboard bench for vga_canvas_renderer on a reduced raster (176x69 total, 128 px canvas of 4 px cells).
module tb_vga_canvas_renderer;
  localparam int H_SYNC = 8, H_BP = 4, H_ACT = 160, H_FP = 4;
  localparam int V_SYNC = 2, V_BP = 2, V_ACT = 64, V_FP = 1;
  localparam int GRID_LOG2 = 5, CELL_LOG2 = 2, CURSOR_R = 2;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int NB    = 1 << (2 * GRID_LOG2);

  logic          clkVga = 1'b0;
  logic          iRstN  = 1'b0;
  logic [3:0]    oRed, oGreen, oBlue;
  logic          oHs, oVs, oFrameStart;
  logic [NB-1:0] oImage;
  logic [NB-1:0] exp_img;

  always #5 clkVga = ~clkVga;

  vga_canvas_renderer_if ctl();

  vga_canvas_renderer #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .GRID_LOG2(GRID_LOG2), .CELL_LOG2(CELL_LOG2), .CURSOR_R(CURSOR_R)
  ) dut (
    .clkVga(clkVga), .iRstN(iRstN), .ctl(ctl),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oHs(oHs), .oVs(oVs), .oFrameStart(oFrameStart), .oImage(oImage)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { string tag; int h; int v; logic [11:0] rgb; } pix_t;
  pix_t q[$];

  task automatic push_raw(input string tag, input int h, input int v, input logic [11:0] rgb);
    pix_t p;
    p.tag = tag; p.h = h; p.v = v; p.rgb = rgb;
    q.push_back(p);
  endtask

  task automatic push(input string tag, input int x, input int y, input logic [11:0] rgb);
    push_raw(tag, x + H_SYNC + H_BP, y + V_SYNC + V_BP, rgb);
  endtask

  // Raster position the DUT is currently presenting (one cycle behind the counters)
  int m_h, m_v, s_h, s_v;
  bit s_valid;
  always @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      m_h <= 0; m_v <= 0; s_h <= 0; s_v <= 0; s_valid <= 1'b0;
    end else begin
      s_h <= m_h; s_v <= m_v; s_valid <= 1'b1;
      if (m_h == H_TOT - 1) begin
        m_h <= 0;
        m_v <= (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  always @(negedge clkVga) begin
    if (iRstN && s_valid) begin
      check("sync", {oHs, oVs, oFrameStart}, {s_h >= H_SYNC, s_v >= V_SYNC, (s_h == 0 && s_v == 0)});
      if (q.size() > 0 && q[0].h == s_h && q[0].v == s_v) begin
        check(q[0].tag, {oRed, oGreen, oBlue}, q[0].rgb);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clkVga);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 3 * FRAME) begin
      @(posedge clkVga);
      n++;
    end
    #1;
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  function automatic int cell_bit(input int x, input int y);
    return (y >> CELL_LOG2) * (1 << GRID_LOG2) + (x >> CELL_LOG2);
  endfunction

  task automatic pen_at(input string tag, input int x, input int y, input bit erase, input bit writes);
    ctl.iCursorX = 11'(x); ctl.iCursorY = 11'(y);
    ctl.iPenDown = 1'b1;   ctl.iErase   = erase;
    tick();
    ctl.iPenDown = 1'b0;   ctl.iErase   = 1'b0;
    if (writes) exp_img[cell_bit(x, y)] = ~erase;
    check(tag, oImage, exp_img);
  endtask

  initial begin
    int busy_n, n;
    ctl.iCursorX = '0; ctl.iCursorY = '0;
    ctl.iPenDown = 1'b0; ctl.iErase = 1'b0; ctl.iClear = 1'b0;
    exp_img = '0;
    repeat (3) @(posedge clkVga);
    #1;
    check("rst_rgb",  {oRed, oGreen, oBlue}, 12'h000);
    check("rst_sync", {oHs, oVs, oFrameStart}, 3'b000);
    check("rst_busy", ctl.oBusy, 1'b0);
    check("rst_img",  oImage, exp_img);
    @(negedge clkVga);
    iRstN = 1'b1;
    tick();

    // Ink cell (40,20) -> row 5 col 10, then park the cursor outside the canvas
    pen_at("ink_40_20", 40, 20, 1'b0, 1'b1);
    ctl.iCursorX = 11'd150; ctl.iCursorY = 11'd50;
    push_raw("px_blank", 0, 0, 12'h222);
    push("px_ink_40_20",   40, 20, 12'hF0F);
    push("px_canvas_44",   44, 20, 12'hFFF);
    push("px_ink_43_23",   43, 23, 12'hF0F);
    push("px_cur_idle",   150, 50, 12'hF00);
    push("px_bg_153",     153, 50, 12'h33F);
    push("px_cur_edge",   152, 52, 12'hF00);
    push("px_canvas_100", 100, 60, 12'hFFF);
    push("px_bg_150_60",  150, 60, 12'h33F);
    drain();

    // Pen held on the inked cell: pen-down cursor colour and box edges
    ctl.iCursorX = 11'd40; ctl.iCursorY = 11'd20; ctl.iPenDown = 1'b1;
    push("px_pen_edge_lo", 38, 18, 12'h00F);
    push("px_pen_out",     37, 20, 12'hFFF);
    push("px_pen_ctr",     40, 20, 12'h00F);
    push("px_pen_edge_hi", 42, 22, 12'h00F);
    push("px_ink_outside", 43, 23, 12'hF0F);
    drain();
    check("pen_hold_img", oImage, exp_img);

    ctl.iErase = 1'b1;
    tick();
    exp_img[cell_bit(40, 20)] = 1'b0;
    check("erase_img", oImage, exp_img);
    push("px_erase_cur", 40, 20, 12'h0F0);
    push("px_erased",    43, 23, 12'hFFF);
    drain();
    ctl.iPenDown = 1'b0; ctl.iErase = 1'b0;
    tick();

    pen_at("pen_out_150_50", 150, 50, 1'b0, 1'b0);
    pen_at("pen_out_128_0",  128,  0, 1'b0, 1'b0);
    pen_at("pen_out_0_128",    0, 128, 1'b0, 1'b0);
    pen_at("pen_corner",     127, 127, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) pen_at("ink_many", i * 12 + 1, i * 8 + 2, 1'b0, 1'b1);

    // Clear with pen held: first on an empty row-31 cell, then on an empty row-0 cell
    ctl.iCursorX = 11'd4; ctl.iCursorY = 11'd124;
    ctl.iPenDown = 1'b1; ctl.iClear = 1'b1;
    tick();
    ctl.iClear = 1'b0;
    check("clr_busy_rise", ctl.oBusy, 1'b1);
    check("clr_no_pen",    oImage, exp_img);
    ctl.iCursorX = 11'd124; ctl.iCursorY = 11'd0;
    busy_n = 1; n = 0;
    while (ctl.oBusy && n < 100) begin
      ctl.iClear = (n == 4);
      tick();
      n++;
      if (ctl.oBusy) busy_n++;
    end
    ctl.iPenDown = 1'b0; ctl.iClear = 1'b0;
    exp_img = '0;
    check("clr_len",      busy_n, 32);
    check("clr_done_img", oImage, exp_img);
    tick();
    check("clr_after_img",  oImage, exp_img);
    check("clr_after_busy", ctl.oBusy, 1'b0);

    // Asynchronous reset in the middle of a sweep
    pen_at("ink_pre_rst", 40, 20, 1'b0, 1'b1);
    ctl.iClear = 1'b1;
    tick();
    ctl.iClear = 1'b0;
    repeat (3) tick();
    #3 iRstN = 1'b0;
    #1;
    exp_img = '0;
    check("arst_rgb",  {oRed, oGreen, oBlue}, 12'h000);
    check("arst_sync", {oHs, oVs, oFrameStart}, 3'b000);
    check("arst_busy", ctl.oBusy, 1'b0);
    check("arst_img",  oImage, exp_img);
    repeat (2) @(negedge clkVga);
    iRstN = 1'b1;
    repeat (2 * H_TOT) tick();
    check("post_rst_busy", ctl.oBusy, 1'b0);
    check("post_rst_img",  oImage, exp_img);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_canvas_renderer.md
# vga_canvas_renderer

Parametrised VGA timing generator and drawing-canvas renderer: the next generation of the 800x600 mouse-drawing display path. It keeps a GRID x GRID binary canvas, paints cells under a cursor supplied by the mouse front-end, and supports erase and a sequenced clear. It drives the VGA pins and exports the canvas bitmap to the image-processing/DNN path. The block runs entirely in the pixel clock domain; cursor and pen inputs arrive already synchronised.

## Interface
Parameters:
- H_SYNC, 128, horizontal sync pulse width (pixels)
- H_BP, 88, horizontal back porch
- H_ACT, 800, horizontal active pixels
- H_FP, 40, horizontal front porch
- V_SYNC, 4 / V_BP, 23 / V_ACT, 600 / V_FP, 1, vertical equivalents (lines)
- GRID_LOG2, 5, canvas is 2^GRID_LOG2 cells per side (32x32)
- CELL_LOG2, 4, each cell is 2^CELL_LOG2 pixels square (16 px)
- CURSOR_R, 8, cursor box half-size in pixels

Ports (clock and reset first):
- clkVga  in  1  pixel clock; the only clock
- iRstN  in  1  reset, asynchronous, active-low
- iCursorX  in  11  cursor pixel column, active-area coordinates
- iCursorY  in  11  cursor pixel row
- iPenDown  in  1  level; paint the cell under the cursor
- iErase  in  1  level; with iPenDown, clear instead of set
- iClear  in  1  one-cycle pulse; start canvas clear
- oBusy  out  1  high while a clear sweep runs
- oRed, oGreen, oBlue  out  4 each  registered colour
- oHs, oVs  out  1 each  registered syncs, active-low
- oFrameStart  out  1  one-cycle pulse at hCnt=0, vCnt=0
- oImage  out  2^(2*GRID_LOG2)  canvas bitmap, bit index {row, col}

## Operation
- Counters: hCnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), wraps to 0; vCnt increments only on hCnt wrap, wraps at V_TOTAL-1. Both are clocked by clkVga (no derived clocks).
- Active: H_SYNC+H_BP <= hCnt < H_SYNC+H_BP+H_ACT, same for v (half-open; exactly H_ACT x V_ACT pixels). hPos/vPos = counter minus sync+porch.
- Canvas region: hPos, vPos < 2^(GRID_LOG2+CELL_LOG2). Cell = {vPos>>CELL_LOG2, hPos>>CELL_LOG2}.
- Colour priority, active area: cursor box (|hPos-iCursorX| <= CURSOR_R and same for y; no unsigned wrap) > inked cell F0F (magenta) > canvas FFF > background 33F. Cursor colour: F00 idle, 00F pen down, 0F0 pen down+erase. Blanking: 222.
- FSM IDLE/CLEAR. IDLE: if iClear then CLEAR, row pointer 0, oBusy 1. Otherwise, if iPenDown and cursor inside canvas region, the cell under the cursor is set (or cleared if iErase) that cycle; outside the region, no write.
- CLEAR: zero one canvas row per cycle; after row 2^GRID_LOG2-1, return to IDLE, oBusy 0. Pen writes and iClear are ignored in CLEAR.
- Simultaneous iClear and iPenDown in IDLE: clear wins; no pen write.

## Timing
- Reset (async assert): hCnt=vCnt=0, canvas all 0, FSM IDLE, oBusy 0, oRGB 000, oHs 0, oVs 0, oFrameStart 0. Deassertion is synchronous to clkVga; first counter increment follows on the next edge.
- Pixel pipeline latency: 1 cycle. oRGB, oHs, oVs and oFrameStart are registered from the same counter values, so all stay aligned.
- Pen write is visible in oImage 1 cycle after the sampling edge. Clear: oBusy rises 1 cycle after iClear and lasts exactly 2^GRID_LOG2 cycles; oImage is all 0 on the edge oBusy falls.
- Reset mid-clear aborts the sweep; the canvas is zeroed by reset.

## Configuration
- VGA_GRID_LINES_EN defined: canvas pixels with hPos or vPos low CELL_LOG2 bits all zero, and not inked or cursor, render CCC (cell grid guide). Undefined: no guide lines; canvas is plain FFF/F0F.

## Test plan
- Reset, release: oRGB=000, oImage=0; line period 1056 cycles, oHs low 128 cycles; frame 628 lines, oVs low 4 lines; oFrameStart once per 663168 cycles.
- Cursor (40,20), iPenDown 1 cycle -> oImage bit 34 (row1, col2) = 1 next cycle; pixel (40,20) reads F00/00F cursor, pixel (300,300) reads FFF.
- Same cursor, iPenDown+iErase -> bit 34 = 0; cursor colour 0F0.
- Cursor (600,100), iPenDown -> no oImage change; background pixel reads 33F.
- Ink 10 cells, pulse iClear with iPenDown held -> oBusy high 32 cycles, no writes, oImage=0 after; iClear during busy is ignored.
- Assert iRstN low mid-clear and mid-line -> all outputs at reset values immediately, without a clock edge.
